mem_handler: RTL and testbench

Load-miss / uncached-load request handler in the LSU memory path. It accepts read requests from the load pipeline and buffers them in a small in-order queue. Requests are issued to the downstream memory listener one at a time, and each returned word goes back to the LSU tagged with its request ID. Pipeline flushes squash both queued and in-flight work.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mh_req_fifo.sv | 70 +++++++
 rtl/mem_handler.sv | 201 ++++++++++++++++++++
 tb/tb_mem_handler.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the mem_handler load-miss request path.
package mem_pkg;

    // Default request tag width. The struct below uses it; the handler
    // itself carries the tag as a flat vector so that ID_W can be overridden.
    localparam int MH_ID_W = 4;

    // Handler FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } MH_STATE_t;

    // One queued load request.
    typedef struct packed {
        logic [31:0]        addr;
        logic [MH_ID_W-1:0] id;
    } MH_REQ_t;

endpackage

// File: rtl/mh_req_fifo.sv
// In-order request FIFO for mem_handler: push/pop/clear with full, empty and
// occupancy count. DEPTH must be a power of two so the pointers wrap naturally.
module mh_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 36
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == {(PTR_W + 1){1'b0}});
    assign count     = count_q;
    assign rdata     = mem_q[rd_ptr_q];
    // A clear wins over any push or pop in the same cycle.
    assign push_ok_s = push & ~full & ~clear;
    assign pop_ok_s  = pop & ~empty & ~clear;

    // Storage array: written only on an accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W + 1){1'b0}};
        end else if (clear) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok_s && !pop_ok_s) begin
                count_q <= count_q + 1'b1;
            end else if (!push_ok_s && pop_ok_s) begin
                count_q <= count_q - 1'b1;
            end else begin
                count_q <= count_q;
            end
        end
    end

endmodule

// File: rtl/mem_handler.sv
// Load-miss / uncached-load request handler. Buffers LSU read requests in an
// in-order queue, issues them one at a time to the memory listener and returns
// each word tagged with its request ID. Flush squashes queued and in-flight work
// while letting an open listener handshake finish.
// Optional feature: define MEM_HANDLER_WATCHDOG_EN to add a WAIT-state watchdog
// and the sticky wd_err output.
module mem_handler
    import mem_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ID_W     = 4,
    parameter int WD_LIMIT = 1023
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_addr,
    input  logic [ID_W-1:0] req_id,
    output logic            ml_valid,
    output logic [31:0]     ml_addr,
    input  logic            ml_received,
    input  logic [31:0]     ml_data,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [31:0]     resp_data,
    output logic [ID_W-1:0] resp_id
`ifdef MEM_HANDLER_WATCHDOG_EN
    ,
    output logic            wd_err
`endif
);
    localparam int FW = 32 + ID_W;

    MH_STATE_t              state_q, state_d;
    logic [31:0]            cur_addr_q, cur_addr_d;
    logic [ID_W-1:0]        cur_id_q, cur_id_d;
    logic                   squash_q, squash_d;
    logic [31:0]            resp_data_q, resp_data_d;
    logic                   ml_valid_q;
    logic                   resp_valid_q;

    logic                   pop_s;
    logic                   bypass_s;
    logic                   push_s;
    logic [FW-1:0]          fifo_rdata_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [$clog2(DEPTH):0] fifo_count_unused_s;

    assign req_ready  = ~fifo_full_s & ~flush;
    // An idle handler with an empty queue takes the new request straight into
    // the current slot so the listener sees it on the very next cycle.
    assign push_s     = req_valid & req_ready & ~bypass_s;

    assign ml_valid   = ml_valid_q;
    assign ml_addr    = cur_addr_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = cur_id_q;

    mh_req_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({req_addr, req_id}),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_unused_s)
    );

    // Next-state logic for the issue/response FSM.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        cur_id_d    = cur_id_q;
        squash_d    = squash_q;
        resp_data_d = resp_data_q;
        pop_s       = 1'b0;
        bypass_s    = 1'b0;
        case (state_q)
            IDLE: begin
                squash_d = 1'b0;
                if (flush) begin
                    state_d = IDLE;
                end else if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    cur_addr_d = fifo_rdata_s[ID_W +: 32];
                    cur_id_d   = fifo_rdata_s[ID_W-1:0];
                    state_d    = WAIT;
                end else if (req_valid) begin
                    bypass_s   = 1'b1;
                    cur_addr_d = req_addr;
                    cur_id_d   = req_id;
                    state_d    = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (ml_received) begin
                    resp_data_d = ml_data;
                    if (squash_q || flush) begin
                        squash_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end else if (flush) begin
                    // Keep the bus transaction open; just forget its result.
                    squash_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                if (flush || resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d  = IDLE;
                squash_d = 1'b0;
            end
        endcase
    end

    // State, current request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_addr_q   <= 32'd0;
            cur_id_q     <= {ID_W{1'b0}};
            squash_q     <= 1'b0;
            resp_data_q  <= 32'd0;
            ml_valid_q   <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            cur_id_q     <= cur_id_d;
            squash_q     <= squash_d;
            resp_data_q  <= resp_data_d;
            ml_valid_q   <= (state_d == WAIT);
            resp_valid_q <= (state_d == RESP);
        end
    end

`ifdef MEM_HANDLER_WATCHDOG_EN
    localparam logic [9:0] WD_LIMIT_C = 10'(WD_LIMIT);

    logic [9:0] wd_cnt_q, wd_cnt_d;
    logic       wd_err_q, wd_err_d;

    // Count cycles spent in WAIT (saturating at the limit) and latch the error.
    always_comb begin
        wd_cnt_d = 10'd0;
        wd_err_d = wd_err_q;
        if (state_q == WAIT) begin
            if (wd_cnt_q != WD_LIMIT_C) begin
                wd_cnt_d = wd_cnt_q + 10'd1;
            end else begin
                wd_cnt_d = wd_cnt_q;
            end
            if (wd_cnt_d == WD_LIMIT_C) begin
                wd_err_d = 1'b1;
            end else begin
                wd_err_d = wd_err_q;
            end
        end else begin
            wd_cnt_d = 10'd0;
        end
    end

    // Watchdog registers; the error is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q <= 10'd0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_err_d;
        end
    end

    assign wd_err = wd_err_q;
`else
    logic wd_limit_unused_s;
    assign wd_limit_unused_s = (WD_LIMIT != 0);
`endif

endmodule

// File: tb/tb_mem_handler.sv
// Self-checking bench for mem_handler: directed vector table, hand-written
// corner-case sequences and a randomized run against a transaction model.
module tb_mem_handler;
    localparam int DEPTH = 4;
    localparam int ID_W  = 4;

    typedef struct packed {
        logic [31:0]     addr;
        logic [ID_W-1:0] id;
    } req_t;

    typedef struct {
        logic [31:0]     addr;
        logic [ID_W-1:0] id;
        logic [31:0]     data;
        int              lat;
        int              hold;
        logic [31:0]     exp_data;
        logic [ID_W-1:0] exp_id;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_addr;
    logic [ID_W-1:0] req_id;
    logic            ml_valid;
    logic [31:0]     ml_addr;
    logic            ml_received;
    logic [31:0]     ml_data;
    logic            resp_valid;
    logic            resp_ready;
    logic [31:0]     resp_data;
    logic [ID_W-1:0] resp_id;
`ifdef MEM_HANDLER_WATCHDOG_EN
    logic            wd_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level reference model.
    req_t        mq[$];
    int          stage;      // 0: nothing in flight, 1: on the bus, 2: awaiting LSU
    req_t        cur;
    logic [31:0] rdat;
    logic        sq;

    vec_t vecs[4];

    always #5 clk = ~clk;

    mem_handler #(
        .DEPTH    (DEPTH),
        .ID_W     (ID_W),
        .WD_LIMIT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_id      (req_id),
        .ml_valid    (ml_valid),
        .ml_addr     (ml_addr),
        .ml_received (ml_received),
        .ml_data     (ml_data),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_id     (resp_id)
`ifdef MEM_HANDLER_WATCHDOG_EN
        ,
        .wd_err      (wd_err)
`endif
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        flush       = 1'b0;
        req_valid   = 1'b0;
        req_addr    = 32'd0;
        req_id      = {ID_W{1'b0}};
        ml_received = 1'b0;
        ml_data     = 32'd0;
        resp_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        #1;
        chk1("rst_mlv", ml_valid, 1'b0);
        chk1("rst_rv", resp_valid, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push_one(input logic [31:0] a, input logic [ID_W-1:0] id);
        req_valid = 1'b1;
        req_addr  = a;
        req_id    = id;
        #1;
        chk1("push_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic serve(input logic [ID_W-1:0] eid, input logic [31:0] d, input logic [31:0] ea);
        int n = 0;
        while (!ml_valid && n < 20) begin
            tick();
            n++;
        end
        chk1("serve_mlv", ml_valid, 1'b1);
        chkw("serve_addr", ml_addr, ea);
        ml_received = 1'b1;
        ml_data     = d;
        tick();
        ml_received = 1'b0;
        chk1("serve_rv", resp_valid, 1'b1);
        chkw("serve_id", 32'(resp_id), 32'(eid));
        chkw("serve_data", resp_data, d);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic run_single(input vec_t v);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_id    = v.id;
        #1;
        chk1("single_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        chk1("single_mlv_n1", ml_valid, 1'b1);
        chkw("single_addr", ml_addr, v.addr);
        repeat (v.lat) begin
            tick();
            chk1("single_mlv_hold", ml_valid, 1'b1);
            chk1("single_rv_early", resp_valid, 1'b0);
        end
        ml_received = 1'b1;
        ml_data     = v.data;
        tick();
        ml_received = 1'b0;
        ml_data     = 32'd0;
        chk1("single_rv", resp_valid, 1'b1);
        chkw("single_data", resp_data, v.exp_data);
        chkw("single_id", 32'(resp_id), 32'(v.exp_id));
        chk1("single_mlv_off", ml_valid, 1'b0);
        repeat (v.hold) begin
            tick();
            chk1("single_rv_hold", resp_valid, 1'b1);
            chkw("single_data_hold", resp_data, v.exp_data);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk1("single_rv_done", resp_valid, 1'b0);
        chk1("single_gap", ml_valid, 1'b0);
    endtask

    initial begin
        vecs[0] = '{addr: 32'h8000_0010, id: 4'd3,  data: 32'hDEAD_BEEF, lat: 1, hold: 0,
                    exp_data: 32'hDEAD_BEEF, exp_id: 4'd3};
        vecs[1] = '{addr: 32'h0000_0000, id: 4'd0,  data: 32'h1234_5678, lat: 0, hold: 2,
                    exp_data: 32'h1234_5678, exp_id: 4'd0};
        vecs[2] = '{addr: 32'hFFFF_FFFC, id: 4'd15, data: 32'h0000_0000, lat: 5, hold: 0,
                    exp_data: 32'h0000_0000, exp_id: 4'd15};
        vecs[3] = '{addr: 32'h0000_4444, id: 4'd9,  data: 32'hFFFF_FFFF, lat: 2, hold: 1,
                    exp_data: 32'hFFFF_FFFF, exp_id: 4'd9};

        // Reset values.
        idle_in();
        rst = 1'b1;
        #1;
        chk1("reset_mlv", ml_valid, 1'b0);
        chk1("reset_rv", resp_valid, 1'b0);
        chkw("reset_addr", ml_addr, 32'd0);
        chkw("reset_data", resp_data, 32'd0);
        chkw("reset_id", 32'(resp_id), 32'd0);
        chk1("reset_ready", req_ready, 1'b1);
`ifdef MEM_HANDLER_WATCHDOG_EN
        chk1("reset_wd", wd_err, 1'b0);
`endif
        tick();
        rst = 1'b0;
        tick();

        // Directed single-request table.
        for (int i = 0; i < 4; i++) begin
            run_single(vecs[i]);
        end

        // Fill the queue behind an in-flight request.
        resp_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            push_one(32'h0000_1000 + 32'(i * 16), ID_W'(i));
        end
        req_valid = 1'b1;
        req_addr  = 32'h0000_2000;
        req_id    = ID_W'(DEPTH + 1);
        #1;
        chk1("full_ready", req_ready, 1'b0);
        chk1("full_mlv", ml_valid, 1'b1);
        chkw("full_addr", ml_addr, 32'h0000_1000);
        ml_received = 1'b1;
        ml_data     = 32'h1111_0000;
        tick();
        ml_received = 1'b0;
        chk1("full_rv", resp_valid, 1'b1);
        chkw("full_id0", 32'(resp_id), 32'd0);
        chk1("full_ready_resp", req_ready, 1'b0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
        chk1("full_ready_idle", req_ready, 1'b0);
        tick();
        #1;
        chk1("pop_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            serve(ID_W'(i), 32'hA5A5_0000 + 32'(i),
                  (i <= DEPTH) ? 32'h0000_1000 + 32'(i * 16) : 32'h0000_2000);
        end

        // Flush while WAIT with two requests queued.
        push_one(32'h0000_3000, 4'd1);
        push_one(32'h0000_3004, 4'd2);
        push_one(32'h0000_3008, 4'd3);
        flush = 1'b1;
        #1;
        chk1("flw_ready", req_ready, 1'b0);
        tick();
        flush = 1'b0;
        chk1("flw_mlv_hold", ml_valid, 1'b1);
        chkw("flw_addr", ml_addr, 32'h0000_3000);
        ml_received = 1'b1;
        ml_data     = 32'hBAD0_BAD0;
        tick();
        ml_received = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1("flw_rv", resp_valid, 1'b0);
            chk1("flw_mlv", ml_valid, 1'b0);
            tick();
        end
        chk1("flw_ready_after", req_ready, 1'b1);

        // Flush together with req_valid and ml_received.
        push_one(32'h0000_5000, 4'd5);
        flush       = 1'b1;
        req_valid   = 1'b1;
        req_addr    = 32'h0000_5004;
        req_id      = 4'd6;
        ml_received = 1'b1;
        ml_data     = 32'hCAFE_F00D;
        #1;
        chk1("fls_ready", req_ready, 1'b0);
        tick();
        idle_in();
        for (int i = 0; i < 4; i++) begin
            chk1("fls_rv", resp_valid, 1'b0);
            chk1("fls_mlv", ml_valid, 1'b0);
            tick();
        end

        // Reset asserted while in RESP with work queued.
        push_one(32'h0000_6000, 4'd7);
        push_one(32'h0000_6004, 4'd8);
        push_one(32'h0000_6008, 4'd9);
        ml_received = 1'b1;
        ml_data     = 32'h7777_7777;
        tick();
        ml_received = 1'b0;
        chk1("rr_rv_before", resp_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk1("rr_rv", resp_valid, 1'b0);
        chk1("rr_mlv", ml_valid, 1'b0);
        chkw("rr_data", resp_data, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk1("rr_idle_mlv", ml_valid, 1'b0);
            chk1("rr_idle_rv", resp_valid, 1'b0);
            tick();
        end
        push_one(32'h0000_7000, 4'd10);
        serve(4'd10, 32'h0A0A_0A0A, 32'h0000_7000);
        chk1("rr_empty_after", ml_valid, 1'b0);

`ifdef MEM_HANDLER_WATCHDOG_EN
        // Watchdog: hold the listener off for 20 cycles.
        chk1("wd_init", wd_err, 1'b0);
        push_one(32'h0000_8000, 4'd4);
        repeat (7) tick();
        chk1("wd_pre", wd_err, 1'b0);
        tick();
        chk1("wd_set", wd_err, 1'b1);
        repeat (11) tick();
        chk1("wd_still_wait", ml_valid, 1'b1);
        ml_received = 1'b1;
        ml_data     = 32'h0BAD_CAFE;
        tick();
        ml_received = 1'b0;
        chk1("wd_rv", resp_valid, 1'b1);
        chkw("wd_data", resp_data, 32'h0BAD_CAFE);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        repeat (3) tick();
        chk1("wd_sticky", wd_err, 1'b1);
`endif

        // Randomized run against the transaction model.
        do_reset();
        mq.delete();
        stage = 0;
        sq    = 1'b0;
        cur   = '0;
        rdat  = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            logic e_mlv, e_rv, e_rr, acc, took;
            flush      = ($urandom_range(0, 24) == 0);
            req_valid  = ($urandom_range(0, 1) == 1);
            req_addr   = $urandom & 32'hFFFF_FFFC;
            req_id     = ID_W'($urandom);
            resp_ready = ($urandom_range(0, 2) != 0);
            ml_data    = $urandom;
            e_mlv      = (stage == 1);
            e_rv       = (stage == 2);
            e_rr       = (mq.size() < DEPTH) && !flush;
            ml_received = e_mlv && ($urandom_range(0, 2) == 0);
            #1;
            chk1("rnd_mlv", ml_valid, e_mlv);
            chk1("rnd_rv", resp_valid, e_rv);
            chk1("rnd_ready", req_ready, e_rr);
            if (e_mlv) begin
                chkw("rnd_addr", ml_addr, cur.addr);
            end
            if (e_rv) begin
                chkw("rnd_data", resp_data, rdat);
                chkw("rnd_id", 32'(resp_id), 32'(cur.id));
            end
            acc  = req_valid && e_rr;
            took = 1'b0;
            case (stage)
                0: begin
                    if (!flush) begin
                        if (mq.size() > 0) begin
                            cur   = mq.pop_front();
                            stage = 1;
                        end else if (acc) begin
                            cur   = '{addr: req_addr, id: req_id};
                            took  = 1'b1;
                            stage = 1;
                        end
                    end
                end
                1: begin
                    if (ml_received) begin
                        if (sq || flush) begin
                            stage = 0;
                            sq    = 1'b0;
                        end else begin
                            stage = 2;
                            rdat  = ml_data;
                        end
                    end else if (flush) begin
                        sq = 1'b1;
                    end
                end
                2: begin
                    if (flush || resp_ready) begin
                        stage = 0;
                    end
                end
                default: stage = 0;
            endcase
            if (flush) begin
                mq.delete();
            end else if (acc && !took) begin
                mq.push_back('{addr: req_addr, id: req_id});
            end
            tick();
        end
        idle_in();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
